// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: states, opcode/ext fields,
// alu_op and condition codes, pc_src/wb_sel encodings and the instruction decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP = 3'd6
`endif
  } state_e;

  // Opcodes [15:12]
  localparam logic [3:0] OP_RR    = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_BCOND = 4'hC;

  // ALU function codes: ext [7:4] of register forms, opcode of immediate forms
  localparam logic [3:0] FN_AND = 4'h1;
  localparam logic [3:0] FN_OR  = 4'h2;
  localparam logic [3:0] FN_XOR = 4'h3;
  localparam logic [3:0] FN_ADD = 4'h5;
  localparam logic [3:0] FN_SUB = 4'h9;
  localparam logic [3:0] FN_CMP = 4'hB;
  localparam logic [3:0] FN_MOV = 4'hD;
  localparam logic [3:0] FN_LUI = 4'hF;

  // ext codes under OP_SHIFT / OP_MEM
  localparam logic [3:0] EXT_LSHI   = 4'h0;
  localparam logic [3:0] EXT_LSHI_N = 4'h1;
  localparam logic [3:0] EXT_LSH    = 4'h4;
  localparam logic [3:0] EXT_LOAD   = 4'h0;
  localparam logic [3:0] EXT_STOR   = 4'h4;
  localparam logic [3:0] EXT_JAL    = 4'h8;
  localparam logic [3:0] EXT_JCOND  = 4'hC;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_CMP = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_MOV = 4'b0110;
  localparam logic [3:0] ALU_LUI = 4'b0111;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4;
  localparam logic [3:0] CC_LS = 4'd5;
  localparam logic [3:0] CC_GT = 4'd6;
  localparam logic [3:0] CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8;
  localparam logic [3:0] CC_FC = 4'd9;
  localparam logic [3:0] CC_LO = 4'd10;
  localparam logic [3:0] CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GE = 4'd13;
  localparam logic [3:0] CC_UC = 4'd14;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_DISP = 2'd1;
  localparam logic [1:0] PC_REG  = 2'd2;

  localparam logic [1:0] WB_RESULT = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_LINK   = 2'd2;

  typedef enum logic [2:0] {
    C_ALU, C_SHIFT, C_LOAD, C_STOR, C_BCOND, C_JCOND, C_JAL, C_ILLEGAL
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [3:0] alu_op;
    logic       imm;
    logic       sext;
    logic       set_flags;
    logic       no_wb;
    logic       src_en;
    logic       dst_en;
    logic       imm_en;
  } dec_t;

  // Returns {valid, alu_op}; LUI only exists as an immediate form.
  function automatic logic [4:0] alu_lookup(input logic [3:0] code, input logic imm);
    case (code)
      FN_AND:  return {1'b1, ALU_AND};
      FN_OR:   return {1'b1, ALU_OR};
      FN_XOR:  return {1'b1, ALU_XOR};
      FN_ADD:  return {1'b1, ALU_ADD};
      FN_SUB:  return {1'b1, ALU_SUB};
      FN_CMP:  return {1'b1, ALU_CMP};
      FN_MOV:  return {1'b1, ALU_MOV};
      FN_LUI:  return {imm, ALU_LUI};
      default: return '0;
    endcase
  endfunction

  function automatic dec_t decode(input logic [3:0] op, input logic [3:0] ext);
    dec_t       d;
    logic [4:0] a;
    d     = '0;
    d.cls = C_ILLEGAL;
    a     = '0;
    if (op == OP_RR) begin
      a = alu_lookup(ext, 1'b0);
      if (a[4]) begin
        d.cls    = C_ALU;
        d.alu_op = a[3:0];
        d.src_en = 1'b1;
        d.dst_en = 1'b1;
      end
    end else if (op == OP_SHIFT) begin
      if (ext == EXT_LSH) begin
        d.cls    = C_SHIFT;
        d.src_en = 1'b1;
        d.dst_en = 1'b1;
      end else if (ext == EXT_LSHI || ext == EXT_LSHI_N) begin
        d.cls    = C_SHIFT;
        d.imm    = 1'b1;
        d.dst_en = 1'b1;
        d.imm_en = 1'b1;
      end
    end else if (op == OP_MEM) begin
      case (ext)
        EXT_LOAD: begin d.cls = C_LOAD;  d.src_en = 1'b1; end
        EXT_STOR: begin d.cls = C_STOR;  d.src_en = 1'b1; d.dst_en = 1'b1; end
        EXT_JAL:  begin d.cls = C_JAL;   d.src_en = 1'b1; end
        EXT_JCOND:begin d.cls = C_JCOND; d.src_en = 1'b1; end
        default:  d.cls = C_ILLEGAL;
      endcase
    end else if (op == OP_BCOND) begin
      d.cls    = C_BCOND;
      d.imm_en = 1'b1;
    end else begin
      a = alu_lookup(op, 1'b1);
      if (a[4]) begin
        d.cls    = C_ALU;
        d.alu_op = a[3:0];
        d.imm    = 1'b1;
        d.dst_en = 1'b1;
        d.imm_en = 1'b1;
      end
    end
    if (d.cls == C_ALU) begin
      d.set_flags = (d.alu_op == ALU_ADD) || (d.alu_op == ALU_SUB) || (d.alu_op == ALU_CMP);
      d.sext      = d.imm && d.set_flags;
      d.no_wb     = (d.alu_op == ALU_CMP);
    end
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_eval.sv
// Branch condition evaluator: cond code against PSR flags {N,Z,F,L,C}.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       taken_o
);

  logic n, z, f, l, c;
  assign {n, z, f, l, c} = flags_i;

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      CC_EQ:   taken_o = z;
      CC_NE:   taken_o = !z;
      CC_CS:   taken_o = c;
      CC_CC:   taken_o = !c;
      CC_HI:   taken_o = l;
      CC_LS:   taken_o = !l;
      CC_GT:   taken_o = n;
      CC_LE:   taken_o = !n;
      CC_FS:   taken_o = f;
      CC_FC:   taken_o = !f;
      CC_LO:   taken_o = !l && !z;
      CC_HS:   taken_o = l || z;
      CC_LT:   taken_o = !n && !z;
      CC_GE:   taken_o = n || z;
      CC_UC:   taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb/branch with memory timeout.
// Define ILLEGAL_TRAP_EN to park in TRAP on an undecodable instruction.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic [4:0]          flags,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                ir_en,
  output logic                src_reg_en,
  output logic                dst_reg_en,
  output logic                imm_reg_en,
  output logic                sign_ext,
  output logic                alu_b_sel,
  output logic                shift_sel,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic                mem_read,
  output logic                mem_write,
  output logic                addr_sel,
  output logic                flags_en,
  output logic                mem_err,
  output logic                illegal
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_err_q, mem_err_d;
  dec_t       dec;
  logic       taken;
  logic       access;
  logic       timeout;
  logic [3:0] unused_rsrc;

  assign dec         = decode(instruction[15:12], instruction[7:4]);
  assign unused_rsrc = instruction[3:0];
  assign access      = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout     = access && !mem_ready && (wait_q == WAIT_LAST);
  assign mem_err     = mem_err_q;

  cond_eval u_cond_eval (
    .cond_i  (instruction[11:8]),
    .flags_i (flags),
    .taken_o (taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    mem_err_d = mem_err_q | timeout;
    if (access && !mem_ready && !timeout) wait_d = wait_q + 8'd1;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          C_ALU, C_SHIFT:          state_d = S_EXEC;
          C_LOAD, C_STOR:          state_d = S_MEM;
          C_BCOND, C_JCOND, C_JAL: state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:                 state_d = S_TRAP;
`else
          default:                 state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC:   state_d = dec.no_wb ? S_FETCH : S_WB;
      S_WB:     state_d = S_FETCH;
      S_MEM: begin
        if (mem_ready)    state_d = (dec.cls == C_LOAD) ? S_WB : S_FETCH;
        else if (timeout) state_d = S_FETCH;
      end
      S_BRANCH: state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Gated by reset so strobes fall the instant reset asserts, not at the next edge.
  always_comb begin
    alu_op     = '0;
    pc_en      = 1'b0;
    pc_src     = PC_INC;
    ir_en      = 1'b0;
    src_reg_en = 1'b0;
    dst_reg_en = 1'b0;
    imm_reg_en = 1'b0;
    sign_ext   = 1'b0;
    alu_b_sel  = 1'b0;
    shift_sel  = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = WB_RESULT;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    flags_en   = 1'b0;
    illegal    = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_en = 1'b1;
            pc_en = 1'b1;
          end
        end
        S_DECODE: begin
          src_reg_en = dec.src_en;
          dst_reg_en = dec.dst_en;
          imm_reg_en = dec.imm_en;
          sign_ext   = dec.sext;
          illegal    = (dec.cls == C_ILLEGAL);
        end
        S_EXEC: begin
          alu_b_sel = dec.imm;
          flags_en  = dec.set_flags;
          if (dec.cls == C_SHIFT) shift_sel = 1'b1;
          else                    alu_op    = ALU_OP_W'(dec.alu_op);
        end
        S_WB: begin
          rf_we  = 1'b1;
          wb_sel = (dec.cls == C_LOAD) ? WB_MEM : WB_RESULT;
        end
        S_MEM: begin
          addr_sel  = 1'b1;
          mem_read  = (dec.cls == C_LOAD);
          mem_write = (dec.cls == C_STOR);
        end
        S_BRANCH: begin
          case (dec.cls)
            C_BCOND: if (taken) begin pc_en = 1'b1; pc_src = PC_DISP; end
            C_JCOND: if (taken) begin pc_en = 1'b1; pc_src = PC_REG;  end
            C_JAL: begin
              rf_we  = 1'b1;
              wb_sel = WB_LINK;
              pc_en  = 1'b1;
              pc_src = PC_REG;
            end
            default: pc_en = 1'b0;
          endcase
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:  illegal = 1'b1;
`endif
        default: illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions plus wait-state,
// timeout, reset and illegal-opcode sequences.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_en;
    logic       src_reg_en;
    logic       dst_reg_en;
    logic       imm_reg_en;
    logic       sign_ext;
    logic       alu_b_sel;
    logic       shift_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic       flags_en;
    logic       illegal;
  } out_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [4:0]  flags;
    int unsigned lat;
    out_t        e1;
    out_t        e2;
    out_t        e3;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [4:0]  flags;
  logic        mem_ready;
  logic [3:0]  alu_op;
  logic        pc_en, ir_en, src_reg_en, dst_reg_en, imm_reg_en, sign_ext;
  logic        alu_b_sel, shift_sel, rf_we, mem_read, mem_write, addr_sel;
  logic        flags_en, mem_err, illegal;
  logic [1:0]  pc_src, wb_sel;
  out_t        cur;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.INSTR_W(16), .ALU_OP_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .flags(flags),
    .mem_ready(mem_ready), .alu_op(alu_op), .pc_en(pc_en), .pc_src(pc_src),
    .ir_en(ir_en), .src_reg_en(src_reg_en), .dst_reg_en(dst_reg_en),
    .imm_reg_en(imm_reg_en), .sign_ext(sign_ext), .alu_b_sel(alu_b_sel),
    .shift_sel(shift_sel), .rf_we(rf_we), .wb_sel(wb_sel), .mem_read(mem_read),
    .mem_write(mem_write), .addr_sel(addr_sel), .flags_en(flags_en),
    .mem_err(mem_err), .illegal(illegal)
  );

  assign cur = {alu_op, pc_en, pc_src, ir_en, src_reg_en, dst_reg_en, imm_reg_en,
                sign_ext, alu_b_sel, shift_sel, rf_we, wb_sel, mem_read, mem_write,
                addr_sel, flags_en, illegal};

  task automatic chk(input string name, input out_t got, input out_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic vec_t mkv(input string n, input logic [15:0] i, input logic [4:0] f,
                               input int unsigned l, input out_t a, input out_t b, input out_t c);
    vec_t v;
    v.name = n; v.instr = i; v.flags = f; v.lat = l; v.e1 = a; v.e2 = b; v.e3 = c;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tv[$];
    out_t Z, F_RDY, F_WAIT, RR, RI, RIS, WB0;
    Z      = '0;
    F_RDY  = '{mem_read: 1'b1, ir_en: 1'b1, pc_en: 1'b1, default: '0};
    F_WAIT = '{mem_read: 1'b1, default: '0};
    RR     = '{src_reg_en: 1'b1, dst_reg_en: 1'b1, default: '0};
    RI     = '{dst_reg_en: 1'b1, imm_reg_en: 1'b1, default: '0};
    RIS    = '{dst_reg_en: 1'b1, imm_reg_en: 1'b1, sign_ext: 1'b1, default: '0};
    WB0    = '{rf_we: 1'b1, default: '0};

    tv.push_back(mkv("ADD", 16'h0152, 5'h00, 4, RR, '{alu_op: 4'b1000, flags_en: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("SUB", 16'h0192, 5'h00, 4, RR, '{alu_op: 4'b0001, flags_en: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("CMP", 16'h01B2, 5'h00, 3, RR, '{alu_op: 4'b0010, flags_en: 1'b1, default: '0}, Z));
    tv.push_back(mkv("AND", 16'h0112, 5'h00, 4, RR, '{alu_op: 4'b0011, default: '0}, WB0));
    tv.push_back(mkv("MOV", 16'h01D2, 5'h00, 4, RR, '{alu_op: 4'b0110, default: '0}, WB0));
    tv.push_back(mkv("ADDI", 16'h51F3, 5'h00, 4, RIS, '{alu_op: 4'b1000, alu_b_sel: 1'b1, flags_en: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("CMPI", 16'hB1F3, 5'h00, 3, RIS, '{alu_op: 4'b0010, alu_b_sel: 1'b1, flags_en: 1'b1, default: '0}, Z));
    tv.push_back(mkv("ORI", 16'h2103, 5'h00, 4, RI, '{alu_op: 4'b0100, alu_b_sel: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("XORI", 16'h3103, 5'h00, 4, RI, '{alu_op: 4'b0101, alu_b_sel: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("LUI", 16'hF312, 5'h00, 4, RI, '{alu_op: 4'b0111, alu_b_sel: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("LSH", 16'h8142, 5'h00, 4, RR, '{shift_sel: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("LSHI", 16'h8103, 5'h00, 4, RI, '{shift_sel: 1'b1, alu_b_sel: 1'b1, default: '0}, WB0));
    tv.push_back(mkv("LOAD", 16'h4102, 5'h00, 4, '{src_reg_en: 1'b1, default: '0},
                     '{addr_sel: 1'b1, mem_read: 1'b1, default: '0}, '{rf_we: 1'b1, wb_sel: 2'd1, default: '0}));
    tv.push_back(mkv("STOR", 16'h4142, 5'h00, 3, RR, '{addr_sel: 1'b1, mem_write: 1'b1, default: '0}, Z));
    tv.push_back(mkv("BEQ_t", 16'hC004, 5'b01000, 3, '{imm_reg_en: 1'b1, default: '0}, '{pc_en: 1'b1, pc_src: 2'd1, default: '0}, Z));
    tv.push_back(mkv("BEQ_n", 16'hC004, 5'b00000, 3, '{imm_reg_en: 1'b1, default: '0}, Z, Z));
    tv.push_back(mkv("BLO_t", 16'hCA04, 5'b00000, 3, '{imm_reg_en: 1'b1, default: '0}, '{pc_en: 1'b1, pc_src: 2'd1, default: '0}, Z));
    tv.push_back(mkv("BLO_n", 16'hCA04, 5'b00010, 3, '{imm_reg_en: 1'b1, default: '0}, Z, Z));
    tv.push_back(mkv("BGE_t", 16'hCD04, 5'b10000, 3, '{imm_reg_en: 1'b1, default: '0}, '{pc_en: 1'b1, pc_src: 2'd1, default: '0}, Z));
    tv.push_back(mkv("BFS_t", 16'hC804, 5'b00100, 3, '{imm_reg_en: 1'b1, default: '0}, '{pc_en: 1'b1, pc_src: 2'd1, default: '0}, Z));
    tv.push_back(mkv("BHI_n", 16'hC404, 5'b11101, 3, '{imm_reg_en: 1'b1, default: '0}, Z, Z));
    tv.push_back(mkv("JUC", 16'h4EC3, 5'h00, 3, '{src_reg_en: 1'b1, default: '0}, '{pc_en: 1'b1, pc_src: 2'd2, default: '0}, Z));
    tv.push_back(mkv("JNV", 16'h4FC3, 5'h1F, 3, '{src_reg_en: 1'b1, default: '0}, Z, Z));
    tv.push_back(mkv("JCS", 16'h42C3, 5'b00001, 3, '{src_reg_en: 1'b1, default: '0}, '{pc_en: 1'b1, pc_src: 2'd2, default: '0}, Z));
    tv.push_back(mkv("JAL", 16'h4E83, 5'h00, 3, '{src_reg_en: 1'b1, default: '0},
                     '{rf_we: 1'b1, wb_sel: 2'd2, pc_en: 1'b1, pc_src: 2'd2, default: '0}, Z));

    reset = 1'b0; instruction = '0; flags = '0; mem_ready = 1'b0;
    #3;
    chk("reset_outputs", cur, Z);
    chk1("reset_mem_err", mem_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("fetch_wait", cur, F_WAIT);
    cyc();

    for (int i = 0; i < tv.size(); i++) begin
      instruction = tv[i].instr; flags = tv[i].flags; mem_ready = 1'b1;
      #1 chk({tv[i].name, "/fetch"}, cur, F_RDY);
      cyc(); chk({tv[i].name, "/decode"}, cur, tv[i].e1);
      cyc(); chk({tv[i].name, "/c3"}, cur, tv[i].e2);
      if (tv[i].lat == 4) begin
        cyc(); chk({tv[i].name, "/c4"}, cur, tv[i].e3);
      end
      cyc();
    end
    chk("table_end_fetch", cur, F_RDY);

    // LOAD with three wait states in MEM
    instruction = 16'h4102; flags = '0; mem_ready = 1'b1;
    #1 chk("ldw/fetch", cur, F_RDY);
    cyc(); mem_ready = 1'b0;
    #1 chk("ldw/decode", cur, '{src_reg_en: 1'b1, default: '0});
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("ldw/mem_wait", cur, '{addr_sel: 1'b1, mem_read: 1'b1, default: '0});
    end
    cyc(); mem_ready = 1'b1;
    #1 chk("ldw/mem_done", cur, '{addr_sel: 1'b1, mem_read: 1'b1, default: '0});
    cyc(); chk("ldw/wb", cur, '{rf_we: 1'b1, wb_sel: 2'd1, default: '0});
    cyc(); chk("ldw/fetch_again", cur, F_RDY);

    // STOR stuck in MEM: abandoned after 15 wait cycles
    instruction = 16'h4142;
    cyc(); mem_ready = 1'b0;
    #1 chk("stto/decode", cur, RR);
    cyc(); chk("stto/mem0", cur, '{addr_sel: 1'b1, mem_write: 1'b1, default: '0});
    for (int k = 1; k <= 14; k++) begin
      cyc(); chk("stto/mem_wait", cur, '{addr_sel: 1'b1, mem_write: 1'b1, default: '0});
    end
    chk1("stto/no_err_yet", mem_err, 1'b0);
    cyc();
    chk("stto/back_to_fetch", cur, F_WAIT);
    chk1("stto/mem_err", mem_err, 1'b1);

    // Asynchronous reset in the middle of a fetch wait
    cyc(); cyc();
    #3 reset = 1'b0;
    #1 chk("rst_mid/outputs", cur, Z);
    chk1("rst_mid/mem_err", mem_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("ftto/start", cur, F_WAIT);

    // Fetch stuck: mem_err after exactly 15 wait cycles, still fetching the same PC
    for (int k = 1; k <= 14; k++) begin
      cyc(); chk1("ftto/no_err", mem_err, 1'b0);
    end
    cyc();
    chk1("ftto/mem_err", mem_err, 1'b1);
    chk("ftto/refetch", cur, F_WAIT);
    #2 reset = 1'b0;
    #1 chk1("ftto/reset_clears", mem_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    instruction = 16'h0E0E; mem_ready = 1'b1;
    #1 chk("ill/fetch", cur, F_RDY);
    cyc(); chk("ill/decode", cur, '{illegal: 1'b1, default: '0});
`ifdef ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("ill/trap_held", cur, '{illegal: 1'b1, default: '0});
    end
    #1 reset = 1'b0;
    #1 chk("ill/trap_reset", cur, Z);
    @(negedge clk);
    reset = 1'b1;
`else
    cyc(); chk("ill/pulse_over", cur, F_RDY);
    instruction = 16'h6000;
    cyc(); chk("ill6/decode", cur, '{illegal: 1'b1, default: '0});
    cyc(); chk("ill6/pulse_over", cur, F_RDY);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised successor to the processor's multicycle control FSM. Decodes the instruction register and sequences every datapath enable and select through fetch, decode, execute, memory and writeback. Adds features the current controller lacks:
- memory wait-state handshake;
- real Bcond/Jcond/JAL evaluation against PSR flags;
- shift instructions;
- flag-write control;
- illegal-opcode detection.

Sits between the instruction register, the PSR and the datapath muxes/registers.

Parameters:
INSTR_W, 16, instruction width; opcode [15:12], cond/Rdest [11:8], ext [7:4], Rsrc/imm [3:0]
ALU_OP_W, 4, width of alu_op
MEM_TIMEOUT, 15, max wait cycles per memory access before mem_err (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instruction  in  INSTR_W  current IR contents
flags  in  5  PSR {N,Z,F,L,C}
mem_ready  in  1  memory access complete this cycle
alu_op  out  ALU_OP_W  ALU operation
pc_en  out  1  PC load
pc_src  out  2  0=PC+1, 1=PC+sext(disp8), 2=Rtarget
ir_en  out  1  IR load
src_reg_en, dst_reg_en, imm_reg_en  out  1 each  operand latches
sign_ext  out  1  sign-extend immediate (0 = zero-extend)
alu_b_sel  out  1  0=register, 1=immediate
shift_sel  out  1  result from shifter instead of ALU
rf_we  out  1  register-file write
wb_sel  out  2  0=result, 1=mem data, 2=PC (link)
mem_read, mem_write  out  1 each  memory strobes
addr_sel  out  1  0=PC, 1=Raddr
flags_en  out  1  PSR update
mem_err  out  1  sticky timeout flag
illegal  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Reset (reset=0, async): state=FETCH, all outputs 0, wait counter 0, mem_err 0.
- Outputs are combinational from state and decode. Unlisted outputs are 0.
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, TRAP (TRAP exists only with the optional feature).
- FETCH:
  - addr_sel=0, mem_read=1.
  - Held until mem_ready. On mem_ready: ir_en=1, pc_en=1, pc_src=0, go to DECODE.
- DECODE:
  - Latch src/dst/imm as the instruction class requires.
  - sign_ext=1 for ADDI/SUBI/CMPI; 0 for ANDI/ORI/XORI/MOVI/LUI.
  - Route: ALU, shift, LUI → EXEC; LOAD, STOR → MEM; Bcond, Jcond, JAL → BRANCH; anything else → illegal.
- EXEC:
  - alu_op encodings: ADD=1000, SUB=0001, CMP=0010, AND=0011, OR=0100, XOR=0101, MOV=0110, LUI=0111.
  - alu_b_sel=1 for immediate forms. shift_sel=1 for LSH/LSHI.
  - flags_en=1 for ADD/SUB/CMP and their immediate forms.
  - CMP/CMPI → FETCH (no writeback). All others → WB.
- WB: rf_we=1, wb_sel per op → FETCH.
- MEM:
  - addr_sel=1; mem_read (LOAD) or mem_write (STOR), held until mem_ready.
  - LOAD → WB with wb_sel=1. STOR → FETCH.
- Memory timeout (FETCH and MEM):
  - Wait counter increments each cycle mem_ready=0 and clears on state exit.
  - At MEM_TIMEOUT: set mem_err, abandon access, go to FETCH (PC unchanged on a fetch timeout).
- BRANCH:
  - Condition taken if cond_eval(cond, flags)=1.
  - Condition codes: EQ0 Z, NE1 !Z, CS2 C, CC3 !C, HI4 L, LS5 !L, GT6 N, LE7 !N, FS8 F, FC9 !F, LO10 !L&!Z, HS11 L|Z, LT12 !N&!Z, GE13 N|Z, UC14 1, 15 never.
  - Bcond taken: pc_en=1, pc_src=1. Jcond taken: pc_en=1, pc_src=2.
  - JAL: rf_we=1, wb_sel=2 (link PC+1 to Rlink), pc_en=1, pc_src=2. Always taken.
  - Not-taken: no PC change. → FETCH.
- Latencies (ready memory): ALU 4 cycles; CMP 3; LOAD 4; STOR 3; branch 3.
- mem_ready=1 outside FETCH/MEM is ignored.
- Reset mid-access drops strobes immediately.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: illegal decode enters TRAP. illegal is held high and no strobes are issued until reset.
- Undefined: illegal pulses for 1 cycle and the instruction executes as NOP → FETCH.

Decomposition:
- Shared package ctrl_pkg: state encoding, opcode/ext constants, alu_op codes, cond codes, pc_src/wb_sel encodings.
- Sub-module cond_eval: combinational (cond[3:0], flags[4:0]) → taken.

Test Plan:
- ADD R1,R2 (0x0152), mem_ready tied 1 → FETCH,DECODE,EXEC(alu_op=1000, flags_en=1),WB(rf_we=1, wb_sel=0) → FETCH in 4 cycles.
- LOAD (0x4102), mem_ready low 3 cycles in MEM → mem_read held 4 cycles, then WB with wb_sel=1.
- BEQ +4 (0xC004): Z=1 → pc_en=1, pc_src=1; Z=0 → pc_en=0; both return to FETCH.
- JAL (0x4E83) → rf_we=1, wb_sel=2, pc_src=2 in a single BRANCH cycle.
- mem_ready stuck 0 in FETCH → mem_err=1 after exactly MEM_TIMEOUT=15 wait cycles; reset low mid-wait → all outputs 0 asynchronously.
- Instruction 0x0E0E (illegal ext) → illegal pulse and return to FETCH; with ILLEGAL_TRAP_EN, illegal stays 1 until reset.
